ip_amba_apb_master_top: RTL and testbench

//  APB4 requester driving one APB slave (ip_amba_apb_slave) over PSEL/PENABLE/PREADY.

---
 rtl/ip_amba_apb_master_top.sv | 217 +++++++++++++++++++++
 tb/tb_ip_amba_apb_master_top.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_amba_apb_master_top.sv
// APB4 requester: accepts one command per cmd_valid/cmd_ready handshake, runs
// the SETUP and ACCESS phases against a single slave, and returns one response
// per command on the rsp_valid/rsp_ready channel. Every output is a flop.
// Optional feature macro: IP_AMBA_APB_MASTER_TIMEOUT_EN bounds the ACCESS-phase
// wait to TIMEOUT_CYCLES consecutive PREADY=0 cycles, then aborts with rsp_err=1.
module ip_amba_apb_master_top #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  output logic [2:0]          PPROT,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Clears the byte-lane offset bits so PADDR is always bus-width aligned.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    for (int i = 0; i < LSB_W; i++) begin
      r[i] = 1'b0;
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                finish;

`ifdef IP_AMBA_APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Consecutive ACCESS wait-cycle counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // State and registered-output flops; reset drops PSEL/PENABLE asynchronously.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    finish      = 1'b0;
`ifdef IP_AMBA_APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          // Command captured straight into the APB output registers.
          state_d     = ST_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = align_addr(cmd_addr);
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? cmd_strb : '0;
          pprot_d     = cmd_prot;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef IP_AMBA_APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (PREADY) begin
          finish      = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end
`ifdef IP_AMBA_APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LAST) begin
          finish      = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
        if (finish) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          pstrb_d     = '0;
          pprot_d     = '0;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;

endmodule

// File: tb/tb_ip_amba_apb_master_top.sv
// Bench for ip_amba_apb_master_top: directed vector table plus randomized
// transactions checked against a transaction-level model of the APB requester.
module tb_ip_amba_apb_master_top;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [2:0]    PPROT;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int total;
  int bad;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;
    logic [DW-1:0] rdata;
    logic          slverr;
    int            rsp_delay;
    logic [AW-1:0] exp_paddr;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t tbl[6];

  ip_amba_apb_master_top #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: aligned address, read data only for reads, error as sampled.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_paddr = (v.addr / SW) * SW;
    r.exp_rdata = v.write ? 32'd0 : v.rdata;
    r.exp_err   = v.slverr;
    return r;
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, ".psel"},    32'(PSEL),    32'd0);
    chk({tag, ".penable"}, 32'(PENABLE), 32'd0);
    chk({tag, ".pwrite"},  32'(PWRITE),  32'd0);
    chk({tag, ".paddr"},   PADDR,        32'd0);
    chk({tag, ".pwdata"},  PWDATA,       32'd0);
    chk({tag, ".pstrb"},   32'(PSTRB),   32'd0);
    chk({tag, ".pprot"},   32'(PPROT),   32'd0);
  endtask

  task automatic apb_outputs(input string tag, input vec_t v, input logic en);
    chk({tag, ".psel"},    32'(PSEL),    32'd1);
    chk({tag, ".penable"}, 32'(PENABLE), 32'(en));
    chk({tag, ".pwrite"},  32'(PWRITE),  32'(v.write));
    chk({tag, ".paddr"},   PADDR,        v.exp_paddr);
    chk({tag, ".pwdata"},  PWDATA,       v.write ? v.wdata : 32'd0);
    chk({tag, ".pstrb"},   32'(PSTRB),   v.write ? 32'(v.strb) : 32'd0);
    chk({tag, ".pprot"},   32'(PPROT),   32'(v.prot));
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  // One full command: handshake, SETUP, ACCESS with waits, held response, handshake.
  task automatic run_txn(input vec_t v, input string tag);
    int n;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    cmd_prot  = v.prot;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk({tag, ".handshake"}, 32'(cmd_ready), 32'd1);
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    // Slave activity before ACCESS must be ignored.
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = $urandom;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_write = ~v.write;
    cmd_strb  = SW'($urandom);
    cmd_prot  = 3'($urandom);
    apb_outputs({tag, ".setup"}, v, 1'b0);
    @(posedge PCLK); #1;
    for (int i = 0; i <= v.waits; i++) begin
      PREADY  = (i == v.waits);
      PRDATA  = (i == v.waits) ? v.rdata : 32'($urandom);
      PSLVERR = (i == v.waits) ? v.slverr : 1'b1;
      apb_outputs($sformatf("%s.access%0d", tag, i), v, 1'b1);
      @(posedge PCLK); #1;
    end
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    PRDATA    = $urandom;
    cmd_valid = (v.rsp_delay > 0);
    for (int i = 0; i <= v.rsp_delay; i++) begin
      rsp_ready = (i == v.rsp_delay);
      chk($sformatf("%s.rsp%0d.valid", tag, i), 32'(rsp_valid), 32'd1);
      chk($sformatf("%s.rsp%0d.rdata", tag, i), rsp_rdata, v.exp_rdata);
      chk($sformatf("%s.rsp%0d.err", tag, i), 32'(rsp_err), 32'(v.exp_err));
      chk($sformatf("%s.rsp%0d.cmd_ready", tag, i), 32'(cmd_ready), 32'd0);
      idle_outputs($sformatf("%s.rsp%0d", tag, i));
      @(posedge PCLK); #1;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    chk({tag, ".done.rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".done.cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".done.psel"}, 32'(PSEL), 32'd0);
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    //            wr    addr           wdata          strb  prot  wt rdata          err  rd paddr          exp_rdata      exp_err
    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'h1111_1111, 1'b0, 0, 32'h0000_0010, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h5555_5555, 4'hF, 3'd2, 3, 32'hCAFE_F00D, 1'b0, 0, 32'h0000_0010, 32'hCAFE_F00D, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 3'd1, 1, 32'h1234_5678, 1'b1, 0, 32'h0000_0010, 32'h1234_5678, 1'b1};
    tbl[3] = '{1'b1, 32'h0000_002C, 32'h0BAD_F00D, 4'h5, 3'd5, 0, 32'hFFFF_FFFF, 1'b0, 5, 32'h0000_002C, 32'h0000_0000, 1'b0};
    tbl[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 4'hF, 3'd7, 2, 32'hA5A5_A5A5, 1'b0, 2, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0101, 32'h0000_00AA, 4'h8, 3'd4, 1, 32'h7777_7777, 1'b1, 1, 32'h0000_0100, 32'h0000_0000, 1'b1};

    // Reset state.
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset.cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    idle_outputs("reset");
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("post_reset.cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      v.write     = 1'($urandom_range(0, 1));
      v.addr      = $urandom;
      v.wdata     = $urandom;
      v.strb      = SW'($urandom);
      v.prot      = 3'($urandom);
      v.waits     = $urandom_range(0, 3);
      v.rdata     = $urandom;
      v.slverr    = 1'($urandom_range(0, 1));
      v.rsp_delay = $urandom_range(0, 2);
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of an ACCESS phase.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h40;
    cmd_prot  = 3'd3;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    @(posedge PCLK); #1;
    chk("rst_mid.penable_before", 32'(PENABLE), 32'd1);
    #3;
    PRESETn = 1'b0;
    #1;
    chk("rst_mid.psel", 32'(PSEL), 32'd0);
    chk("rst_mid.penable", 32'(PENABLE), 32'd0);
    chk("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid.cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_mid.paddr", PADDR, 32'd0);
    @(posedge PCLK); #3;
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    PRDATA  = 32'hBAD0_BAD0;
    @(posedge PCLK); #1;
    chk("rst_rel.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rel.rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_rel.rsp_valid_late", 32'(rsp_valid), 32'd0);
    chk("rst_rel.psel_late", 32'(PSEL), 32'd0);
    PREADY = 1'b0;
    run_txn(tbl[0], "after_rst");

`ifdef IP_AMBA_APB_MASTER_TIMEOUT_EN
    // PREADY stuck low: abort after TIMEOUT_CYCLES (4) wait cycles.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h80;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = 32'h1357_9BDF;
    @(posedge PCLK); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("timeout.wait%0d.penable", i), 32'(PENABLE), 32'd1);
      chk($sformatf("timeout.wait%0d.rsp_valid", i), 32'(rsp_valid), 32'd0);
      @(posedge PCLK); #1;
    end
    chk("timeout.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("timeout.rsp_err", 32'(rsp_err), 32'd1);
    chk("timeout.rsp_rdata", rsp_rdata, 32'd0);
    chk("timeout.psel", 32'(PSEL), 32'd0);
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    chk("timeout.done.cmd_ready", 32'(cmd_ready), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
